// File: rtl/tinyqv_data_responder_if.sv
// TinyQV data-bus bundle between the CPU (master) and a data responder (slave).
interface tinyqv_data_responder_if;
    logic [27:0] data_addr;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out;
    logic        data_continue;
    logic        data_ready;
    logic [31:0] data_in;

    modport master (
        output data_addr, data_write_n, data_read_n, data_out, data_continue,
        input  data_ready, data_in
    );

    modport slave (
        input  data_addr, data_write_n, data_read_n, data_out, data_continue,
        output data_ready, data_in
    );
endinterface

// File: rtl/tinyqv_data_responder.sv
// Scratchpad RAM on the TinyQV data bus: 8/16/32-bit accesses completed after LATENCY cycles.
// Optional TINYQV_DATA_RESP_BURST_EN: a sequential access flagged by data_continue completes in one cycle.
module tinyqv_data_responder #(
    parameter logic [3:0] REGION     = 4'h1,
    parameter int         DEPTH_LOG2 = 6,
    parameter int         LATENCY    = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    tinyqv_data_responder_if.slave        bus
);

    localparam int         DEPTH   = 1 << DEPTH_LOG2;
    localparam int         IDX_W   = DEPTH_LOG2;
    localparam logic [3:0] LAT_M1  = 4'(LATENCY - 1);
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_NONE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    function automatic logic [31:0] lane_read(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane);
        logic [31:0] res;
        res = 32'h0000_0000;
        case (size)
            SZ_BYTE: res[7:0]  = word[{lane, 3'b000} +: 8];
            SZ_HALF: res[15:0] = word[{lane[1], 4'b0000} +: 16];
            default: res       = word;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lane,
                                               input logic [31:0] wdata);
        logic [31:0] res;
        res = word;
        case (size)
            SZ_BYTE: res[{lane, 3'b000} +: 8]     = wdata[7:0];
            SZ_HALF: res[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            default: res                           = wdata;
        endcase
        return res;
    endfunction

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [1:0]         lane_q, lane_d;
    logic [1:0]         size_q, size_d;
    logic               write_q, write_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               data_ready_q, data_ready_d;
    logic [31:0]        data_in_q, data_in_d;
    logic [31:0]        mem_q [DEPTH];

    logic               wr_req_s, rd_req_s, req_s;
    logic [1:0]         req_size_s;
    logic [IDX_W-1:0]   req_idx_s;
    logic               burst_hit_s;
    logic [IDX_W-1:0]   acc_idx_s;
    logic [1:0]         acc_lane_s, acc_size_s;
    logic               acc_write_s;
    logic               mem_we_s;
    logic [31:0]        mem_wdata_s;

    // Request decode; a write wins over a simultaneous read, so size 11 is never taken.
    always_comb begin
        wr_req_s   = (bus.data_write_n != SZ_NONE);
        rd_req_s   = (bus.data_read_n != SZ_NONE);
        req_s      = (wr_req_s || rd_req_s) && (bus.data_addr[27:24] == REGION);
        req_size_s = wr_req_s ? bus.data_write_n : bus.data_read_n;
        req_idx_s  = bus.data_addr[DEPTH_LOG2+1:2];
    end

`ifdef TINYQV_DATA_RESP_BURST_EN
    logic               cont_q, cont_d;
    logic               burst_vld_q, burst_vld_d;
    logic [IDX_W-1:0]   burst_idx_q, burst_idx_d;
    logic               unused_s;

    assign unused_s = ^{bus.data_addr[23:DEPTH_LOG2+2]};

    // Fast path only for the request captured in the IDLE cycle right after the ACK.
    always_comb begin
        burst_hit_s = burst_vld_q && (req_idx_s == burst_idx_q);
    end

    // Burst tracker: armed at ACK, consumed or dropped by the following IDLE cycle.
    always_comb begin
        cont_d      = cont_q;
        burst_vld_d = burst_vld_q;
        burst_idx_d = burst_idx_q;
        case (state_q)
            ST_IDLE: begin
                burst_vld_d = 1'b0;
                if (req_s) begin
                    cont_d = bus.data_continue;
                end else begin
                    cont_d = 1'b0;
                end
            end
            ST_ACK: begin
                burst_vld_d = cont_q;
                burst_idx_d = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
            end
            default: begin
                cont_d = cont_q;
            end
        endcase
    end

    // Burst tracker registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cont_q      <= 1'b0;
            burst_vld_q <= 1'b0;
            burst_idx_q <= {IDX_W{1'b0}};
        end else begin
            cont_q      <= cont_d;
            burst_vld_q <= burst_vld_d;
            burst_idx_q <= burst_idx_d;
        end
    end
`else
    logic unused_s;

    assign unused_s = ^{bus.data_addr[23:DEPTH_LOG2+2], bus.data_continue};

    // Without the burst option every access takes the full latency.
    always_comb begin
        burst_hit_s = 1'b0;
    end
`endif

    // Next-state logic and request capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        lane_d  = lane_q;
        size_d  = size_q;
        write_d = write_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_s) begin
                    idx_d   = req_idx_s;
                    lane_d  = bus.data_addr[1:0];
                    size_d  = req_size_s;
                    write_d = wr_req_s;
                    wdata_d = bus.data_out;
                    if ((LATENCY <= 1) || burst_hit_s) begin
                        state_d = ST_ACK;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = LAT_M1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d = ST_ACK;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Outputs: read data is latched on entry to ACK so it is valid alongside data_ready.
    always_comb begin
        if (state_q == ST_IDLE) begin
            acc_idx_s   = req_idx_s;
            acc_lane_s  = bus.data_addr[1:0];
            acc_size_s  = req_size_s;
            acc_write_s = wr_req_s;
        end else begin
            acc_idx_s   = idx_q;
            acc_lane_s  = lane_q;
            acc_size_s  = size_q;
            acc_write_s = write_q;
        end
        data_ready_d = (state_d == ST_ACK);
        if ((state_d == ST_ACK) && !acc_write_s) begin
            data_in_d = lane_read(mem_q[acc_idx_s], acc_size_s, acc_lane_s);
        end else begin
            data_in_d = data_in_q;
        end
        mem_we_s    = (state_q == ST_ACK) && write_q;
        mem_wdata_s = lane_merge(mem_q[idx_q], size_q, lane_q, wdata_q);
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            idx_q        <= {IDX_W{1'b0}};
            lane_q       <= 2'b00;
            size_q       <= 2'b00;
            write_q      <= 1'b0;
            wdata_q      <= 32'h0000_0000;
            data_ready_q <= 1'b0;
            data_in_q    <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            lane_q       <= lane_d;
            size_q       <= size_d;
            write_q      <= write_d;
            wdata_q      <= wdata_d;
            data_ready_q <= data_ready_d;
            data_in_q    <= data_in_d;
        end
    end

    // Word array is not reset; a reset during ACK suppresses the pending write.
    always_ff @(posedge clk) begin
        if (mem_we_s && !rst) begin
            mem_q[idx_q] <= mem_wdata_s;
        end
    end

    assign bus.data_ready = data_ready_q;
    assign bus.data_in    = data_in_q;

endmodule
